// File: rtl/usb_tx_pkg.sv
// Shared constants and state encoding for the USB full-speed transmit bit engine.
package usb_tx_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LEN    = 6;
  localparam int         EOP_SE0_BITS = 2;

  // Line states packed as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/usb_tx_serializer_nrzi.sv
// Registered D+/D- line driver: NRZI on each strobe, with SE0/J overrides for EOP.
module nrzi_encoder
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       tx_bit,
  input  logic       force_se0,
  input  logic       force_j,
  output logic [1:0] line
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line <= LINE_J;
    end else if (strobe) begin
      if (force_se0)   line <= LINE_SE0;
      else if (force_j) line <= LINE_J;
      else if (!tx_bit) line <= (line == LINE_J) ? LINE_K : LINE_J;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB FS transmit serializer: SYNC, LSB-first payload with bit stuffing, NRZI, EOP.
module usb_tx_serializer
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  output logic       tx_byte_req,
  output logic       timer_clear,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);
  localparam logic [1:0] SE0_MAX   = 2'(EOP_SE0_BITS);

  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] bit_cnt, ones_cnt, ones_next;
  logic [1:0] eop_cnt, line;
  logic       last_q, byte_end;
  logic       stuff_due, byte_wrap, enc_strobe, force_se0, force_j, tx_bit;

  always_comb begin
    ones_next   = shift[0] ? ((ones_cnt == STUFF_MAX) ? ones_cnt : ones_cnt + 3'd1) : 3'd0;
    stuff_due   = (ones_next == STUFF_MAX);
    byte_wrap   = (bit_cnt == 3'd7);
    tx_bit      = (state == ST_STUFF) ? 1'b0 : shift[0];
    enc_strobe  = bit_strobe && (state != ST_IDLE);
    force_se0   = (state == ST_EOP_SE0) && (eop_cnt < SE0_MAX);
    force_j     = ((state == ST_EOP_SE0) && (eop_cnt >= SE0_MAX)) || (state == ST_EOP_J);
    timer_clear = (state == ST_IDLE) && tx_start;
    tx_byte_req = 1'b0;
    case (state)
      ST_SYNC:  tx_byte_req = bit_strobe && byte_wrap;
      ST_DATA:  tx_byte_req = bit_strobe && byte_wrap && !stuff_due && !last_q;
      // a stuff bit trailing bit 7 of a non-final byte defers that byte's pop
      ST_STUFF: tx_byte_req = bit_strobe && byte_end && !last_q;
      default:  tx_byte_req = 1'b0;
    endcase
  end

  assign tx_busy                = (state != ST_IDLE);
  assign {dplus_out, dminus_out} = line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      eop_cnt  <= '0;
      last_q   <= 1'b0;
      byte_end <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: if (tx_start) begin
          state    <= ST_SYNC;
          shift    <= SYNC_BYTE;
          bit_cnt  <= '0;
          ones_cnt <= '0;
          byte_end <= 1'b0;
        end
        ST_SYNC: if (bit_strobe) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_wrap) begin
            shift    <= tx_byte;
            last_q   <= tx_last;
            ones_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: if (bit_strobe) begin
          shift    <= shift >> 1;
          bit_cnt  <= bit_cnt + 3'd1;
          ones_cnt <= ones_next;
          if (stuff_due) begin
            state    <= ST_STUFF;
            byte_end <= byte_wrap;
          end else if (byte_wrap) begin
            if (!last_q) begin
              shift  <= tx_byte;
              last_q <= tx_last;
            end else begin
              state   <= ST_EOP_SE0;
              eop_cnt <= '0;
            end
          end
        end
        ST_STUFF: if (bit_strobe) begin
          ones_cnt <= '0;
          byte_end <= 1'b0;
          if (byte_end && last_q) begin
            state   <= ST_EOP_SE0;
            eop_cnt <= '0;
          end else begin
            state <= ST_DATA;
            if (byte_end) begin
              shift  <= tx_byte;
              last_q <= tx_last;
            end
          end
        end
        ST_EOP_SE0: if (bit_strobe) begin
          if (force_se0) eop_cnt <= eop_cnt + 2'd1;
          else           state   <= ST_EOP_J;
        end
        ST_EOP_J: if (bit_strobe) begin
          state   <= ST_IDLE;
          tx_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  nrzi_encoder u_nrzi (
    .clk       (clk),
    .rst       (rst),
    .strobe    (enc_strobe),
    .tx_bit    (tx_bit),
    .force_se0 (force_se0),
    .force_j   (force_j),
    .line      (line)
  );

endmodule
